router_pkt_reg: RTL and testbench

Parametrised packet register stage for the 1xN router. It sits between the input port and the destination FIFOs and is driven by the router FSM state strobes. It latches the header, steers payload to the FIFO write path, and holds one byte while the FIFO is full. It computes a selectable parity/checksum and checks both the packet parity and the header-declared payload length.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_chk_acc.sv | 30 +++
 rtl/router_pkt_reg.sv | 135 +++++++++++++
 tb/tb_router_pkt_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router packet datapath.
package router_pkg;

  localparam int PAR_XOR = 0;
  localparam int PAR_SUM = 1;

  localparam int DEF_DW  = 8;
  localparam int DEF_NCH = 3;

  // Ceiling log2; values of 0 or 1 give 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Running parity accumulator: XOR (LRC) or wrapping additive checksum.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int MODE = PAR_XOR
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clr_i,
  input  logic          seed_i,
  input  logic [DW-1:0] seed_val_i,
  input  logic          upd_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] acc_q;

  // Clear beats seed beats update; the sum wraps naturally at DW bits.
  always_ff @(posedge clock) begin
    if (!resetn)     acc_q <= '0;
    else if (clr_i)  acc_q <= '0;
    else if (seed_i) acc_q <= seed_val_i;
    else if (upd_i)  acc_q <= (MODE == PAR_SUM) ? acc_q + data_i : acc_q ^ data_i;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/router_pkt_reg.sv
// Packet register stage: header latch, FIFO write steering with one-byte
// full holding, parity/checksum and header-length checking.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NCH      = DEF_NCH,
  parameter int PAR_MODE = PAR_XOR,
  parameter int CW       = 8,
  localparam int AW      = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] hdr_addr,
  output logic          hdr_valid,
  output logic          low_packet_valid,
  output logic          parity_done,
  output logic          err,
  output logic          len_err,
  output logic [CW-1:0] err_count
);

  localparam int LW = DW - AW;
  localparam logic [AW:0] NCH_W = NCH[AW:0];

  logic [DW-1:0] hdr_q, hdr_d, dout_q, dout_d, hold_q, hold_d, ext_par_q, ext_par_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] pay_cnt_q, pay_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hvld_q, hvld_d, hold_v_q, hold_v_d, lpv_q, lpv_d;
  logic          pdone_q, pdone_d, pdly_q, pdly_d, err_q, err_d, lerr_q, lerr_d;
  logic          acc_clr, acc_seed, acc_upd;
  logic [DW-1:0] acc;
  logic [AW-1:0] in_addr;
  logic [LW-1:0] hdr_len;
  logic          bad_par, bad_len;

  assign in_addr = data_in[AW-1:0];
  assign hdr_len = hdr_q[DW-1:AW];
  assign bad_par = (acc != ext_par_q);
  assign bad_len = (pay_cnt_q != hdr_len);

  router_chk_acc #(.DW(DW), .MODE(PAR_MODE)) u_acc (
    .clock      (clock),
    .resetn     (resetn),
    .clr_i      (acc_clr),
    .seed_i     (acc_seed),
    .seed_val_i (hdr_q),
    .upd_i      (acc_upd),
    .data_i     (data_in),
    .acc_o      (acc)
  );

  // Next-state: full_state freezes everything; otherwise strobes in priority order.
  always_comb begin
    hdr_d = hdr_q; addr_d = addr_q; hvld_d = hvld_q; dout_d = dout_q;
    hold_d = hold_q; hold_v_d = hold_v_q; pay_cnt_d = pay_cnt_q; ext_par_d = ext_par_q;
    lpv_d = lpv_q; pdone_d = pdone_q; pdly_d = pdly_q; err_d = err_q; lerr_d = lerr_q;
    cnt_d = cnt_q;
    acc_clr = 1'b0; acc_seed = 1'b0; acc_upd = 1'b0;
    if (!full_state) begin
      if (detect_add && pkt_valid) begin
        if ({1'b0, in_addr} < NCH_W) begin
          hdr_d  = data_in;
          addr_d = in_addr;
          hvld_d = 1'b1;
        end else begin
          hvld_d = 1'b0;
        end
        acc_clr = 1'b1; pay_cnt_d = '0; ext_par_d = '0;
        pdone_d = 1'b0; pdly_d = 1'b0; err_d = 1'b0; lerr_d = 1'b0;
      end else begin
        if (lfd_state) begin
          dout_d = hdr_q; acc_seed = 1'b1; pay_cnt_d = '0;
        end else if (ld_state) begin
          if (pkt_valid) begin
            acc_upd = 1'b1;
            if (pay_cnt_q != '1) pay_cnt_d = pay_cnt_q + 1'b1;
          end else begin
            ext_par_d = data_in; lpv_d = 1'b1; pdone_d = 1'b1;
          end
          if (!fifo_full) dout_d = data_in;
          else begin
            hold_d = data_in; hold_v_d = 1'b1;
          end
        end else if (laf_state && hold_v_q) begin
          dout_d = hold_q; hold_v_d = 1'b0;
        end
        // One-shot check on the edge after parity_done rises.
        pdly_d = pdone_q;
        if (pdone_q && !pdly_q) begin
          err_d  = bad_par;
          lerr_d = bad_len;
          if ((bad_par || bad_len) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      if (rst_int_reg) begin
        lpv_d = 1'b0; hold_v_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q <= '0; addr_q <= '0; hvld_q <= 1'b0; dout_q <= '0; hold_q <= '0;
      hold_v_q <= 1'b0; pay_cnt_q <= '0; ext_par_q <= '0; lpv_q <= 1'b0;
      pdone_q <= 1'b0; pdly_q <= 1'b0; err_q <= 1'b0; lerr_q <= 1'b0; cnt_q <= '0;
    end else begin
      hdr_q <= hdr_d; addr_q <= addr_d; hvld_q <= hvld_d; dout_q <= dout_d; hold_q <= hold_d;
      hold_v_q <= hold_v_d; pay_cnt_q <= pay_cnt_d; ext_par_q <= ext_par_d; lpv_q <= lpv_d;
      pdone_q <= pdone_d; pdly_q <= pdly_d; err_q <= err_d; lerr_q <= lerr_d; cnt_q <= cnt_d;
    end
  end

  assign dout             = dout_q;
  assign hdr_addr         = addr_q;
  assign hdr_valid        = hvld_q;
  assign low_packet_valid = lpv_q;
  assign parity_done      = pdone_q;
  assign err              = err_q;
  assign len_err          = lerr_q;
  assign err_count        = cnt_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed bench: one XOR-mode and one sum-mode instance share the stimulus.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;

  logic [7:0] dout_x, dout_s;
  logic [1:0] addr_x, addr_s;
  logic       hv_x, hv_s, lpv_x, lpv_s, pd_x, pd_s, err_x, err_s, le_x, le_s;
  logic [7:0] cnt_x, cnt_s;

  int checks = 0;
  int failures = 0;
  logic held = 1'b0;

  always #5 clock = ~clock;

  router_pkt_reg #(.DW(8), .NCH(3), .PAR_MODE(0), .CW(8)) u_x (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_x), .hdr_addr(addr_x), .hdr_valid(hv_x),
    .low_packet_valid(lpv_x), .parity_done(pd_x), .err(err_x), .len_err(le_x),
    .err_count(cnt_x));

  router_pkt_reg #(.DW(8), .NCH(3), .PAR_MODE(1), .CW(8)) u_s (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_s), .hdr_addr(addr_s), .hdr_valid(hv_s),
    .low_packet_valid(lpv_s), .parity_done(pd_s), .err(err_s), .len_err(le_s),
    .err_count(cnt_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply strobes/data, clock, then settle 1ns past the edge.
  task automatic step(input logic da, input logic lfd, input logic ld, input logic laf,
                      input logic fs, input logic rir, input logic pv, input logic ff,
                      input logic [7:0] d);
    if (ld && ff && held) begin
      $display("FAIL stim_guard: second full byte while one is held");
      $fatal(1);
    end
    if (ld && ff) held = 1'b1;
    if ((laf && held) || rir) held = 1'b0;
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  // Header + lfd + three payload bytes + parity byte, checking dout each edge.
  task automatic pkt(input string tag, input logic [7:0] h, input logic [7:0] p0,
                     input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] par);
    step(1, 0, 0, 0, 0, 0, 1, 0, h);
    chk({tag, "_hvld"}, 32'(hv_x), 32'h1);
    chk({tag, "_addr"}, 32'(addr_x), 32'(h[1:0]));
    chk({tag, "_err_clr"}, 32'({err_x, le_x, err_s, le_s}), 32'h0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    chk({tag, "_dout_h"}, 32'(dout_x), 32'(h));
    step(0, 0, 1, 0, 0, 0, 1, 0, p0);
    chk({tag, "_dout_0"}, 32'(dout_x), 32'(p0));
    step(0, 0, 1, 0, 0, 0, 1, 0, p1);
    chk({tag, "_dout_1"}, 32'(dout_s), 32'(p1));
    step(0, 0, 1, 0, 0, 0, 1, 0, p2);
    chk({tag, "_dout_2"}, 32'(dout_x), 32'(p2));
    step(0, 0, 1, 0, 0, 0, 0, 0, par);
    chk({tag, "_dout_p"}, 32'(dout_x), 32'(par));
    chk({tag, "_pdone_lpv"}, 32'({pd_x, lpv_x, pd_s, lpv_s}), 32'hF);
    chk({tag, "_err_late"}, 32'({err_x, err_s}), 32'h0);
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_x", 32'({dout_x, addr_x, hv_x, lpv_x, pd_x, err_x, le_x, cnt_x}), 32'h0);
    chk("rst_s", 32'({dout_s, addr_s, hv_s, lpv_s, pd_s, err_s, le_s, cnt_s}), 32'h0);
    resetn = 1'b1;

    // Good XOR packet; sum instance sees 0x73 != 0x0D.
    pkt("A", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    chk("A_x_flags", 32'({err_x, le_x}), 32'h0);
    chk("A_x_cnt", 32'(cnt_x), 32'd0);
    chk("A_s_err", 32'(err_s), 32'h1);
    chk("A_s_cnt", 32'(cnt_s), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("A_rst_int", 32'({lpv_x, lpv_s}), 32'h0);

    // Bad parity for both modes.
    pkt("B", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E);
    chk("B_x_err", 32'({err_x, le_x}), 32'h2);
    chk("B_x_cnt", 32'(cnt_x), 32'd1);
    chk("B_s_cnt", 32'(cnt_s), 32'd2);
    idle();
    chk("B_err_hold", 32'(err_x), 32'h1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

    // Correct checksum for sum mode.
    pkt("C", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h73);
    chk("C_s_err", 32'({err_s, le_s}), 32'h0);
    chk("C_s_cnt", 32'(cnt_s), 32'd2);
    chk("C_x_err", 32'(err_x), 32'h1);
    chk("C_x_cnt", 32'(cnt_x), 32'd2);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

    // Header declares 4 bytes, only 3 sent.
    pkt("D", 8'h11, 8'h11, 8'h22, 8'h33, 8'h11);
    chk("D_x_flags", 32'({err_x, le_x}), 32'h1);
    chk("D_x_cnt", 32'(cnt_x), 32'd3);
    chk("D_s_cnt", 32'(cnt_s), 32'd3);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

    // FIFO full during 0x22: held, released on laf_state.
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0D);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 0, 0, 1, 1, 8'h22);
    chk("E_dout_stall", 32'(dout_x), 32'h11);
    step(0, 0, 0, 0, 1, 0, 1, 1, 8'h55);
    chk("E_dout_full", 32'(dout_x), 32'h11);
    step(0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
    chk("E_dout_laf", 32'(dout_x), 32'h22);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h33);
    chk("E_dout_33", 32'(dout_x), 32'h33);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h0D);
    chk("E_dout_par", 32'(dout_x), 32'h0D);
    idle();
    chk("E_flags", 32'({err_x, le_x, err_s}), 32'h1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

    // Out-of-range address.
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h03);
    chk("F_hvld", 32'(hv_x), 32'h0);
    chk("F_addr", 32'(addr_x), 32'h1);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("F_hdr_kept", 32'(dout_x), 32'h0D);

    // Reset mid-payload.
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h0D);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
    resetn = 1'b0;
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h22);
    chk("G_rst_x", 32'({dout_x, addr_x, hv_x, lpv_x, pd_x, err_x, le_x, cnt_x}), 32'h0);
    chk("G_rst_s", 32'({dout_s, addr_s, hv_s, lpv_s, pd_s, err_s, le_s, cnt_s}), 32'h0);
    resetn = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
